// File: rtl/fifo_flagged_if.sv
// Push/pop and status bundle for fifo_flagged: producer/consumer side is the master,
// the FIFO itself is the slave.
interface fifo_flagged_if #(
  parameter int FIFO_WIDTH  = 8,
  parameter int FIFO_CNTR_W = 5
);
  logic                   push;
  logic                   pop;
  logic [FIFO_WIDTH-1:0]  data_in;
  logic [FIFO_WIDTH-1:0]  data_out;
  logic [FIFO_CNTR_W-1:0] count;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output push, pop, data_in,
    input  data_out, count, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, count, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_flagged.sv
// Flagged synchronous FIFO with occupancy count, thresholds and sticky error bits.
// Define FIFO_FWFT_EN for first-word fall-through; default is registered read data.
module fifo_flagged #(
  parameter int FIFO_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int FIFO_PNTR_W = 4,
  parameter int FIFO_CNTR_W = 5,
  parameter int AF_THRESH   = 12,
  parameter int AE_THRESH   = 2
) (
  input logic           clk,
  input logic           FIFO_reset,
  input logic           FIFO_clr_n,
  fifo_flagged_if.slave bus
);

  logic [FIFO_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [FIFO_PNTR_W-1:0] wp_q, wp_d;
  logic [FIFO_PNTR_W-1:0] rp_q, rp_d;
  logic [FIFO_CNTR_W-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   full, empty;
  logic                   push_acc, pop_acc, wr_en;
`ifndef FIFO_FWFT_EN
  logic [FIFO_WIDTH-1:0]  dout_q, dout_d;
`endif

  assign full  = (count_q == FIFO_CNTR_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // A pop frees the head slot, so a push into a full FIFO is accepted alongside it.
  always_comb begin
    pop_acc  = bus.pop && !empty;
    push_acc = bus.push && (!full || pop_acc);
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    wr_en    = 1'b0;
`ifndef FIFO_FWFT_EN
    dout_d   = dout_q;
`endif
    if (!FIFO_clr_n) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
`ifndef FIFO_FWFT_EN
      dout_d  = '0;
`endif
    end else begin
      wr_en = push_acc;
      if (push_acc) wp_d = wp_q + FIFO_PNTR_W'(1);
      if (pop_acc) begin
        rp_d = rp_q + FIFO_PNTR_W'(1);
`ifndef FIFO_FWFT_EN
        dout_d = mem_q[rp_q];
`endif
      end
      if (push_acc && !pop_acc)      count_d = count_q + FIFO_CNTR_W'(1);
      else if (pop_acc && !push_acc) count_d = count_q - FIFO_CNTR_W'(1);
      if (bus.push && !push_acc) ovf_d = 1'b1;
      if (bus.pop && !pop_acc)   udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge FIFO_reset) begin
    if (FIFO_reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
`ifndef FIFO_FWFT_EN
      dout_q  <= '0;
`endif
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
`ifndef FIFO_FWFT_EN
      dout_q  <= dout_d;
`endif
    end
  end

  // Storage is neither reset nor cleared; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= bus.data_in;
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = empty ? '0 : mem_q[rp_q];
`else
  assign bus.data_out = dout_q;
`endif
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= FIFO_CNTR_W'(AF_THRESH));
  assign bus.almost_empty = (count_q <= FIFO_CNTR_W'(AE_THRESH));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: vector table plus sequences checked against a queue model.
module tb_fifo_flagged;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int PW = 4;
  localparam int CW = 5;
  localparam int AF = 12;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic FIFO_reset;
  logic FIFO_clr_n;

  fifo_flagged_if #(.FIFO_WIDTH(W), .FIFO_CNTR_W(CW)) bus ();

  fifo_flagged #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(D), .FIFO_PNTR_W(PW), .FIFO_CNTR_W(CW),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .FIFO_reset(FIFO_reset), .FIFO_clr_n(FIFO_clr_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // flags packed as {full, empty, almost_full, almost_empty, overflow, underflow}
  typedef struct {
    logic       clr_n, push, pop;
    logic [7:0] din;
    int         cnt;
    logic [5:0] flags;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [5:0] dut_flags();
    return {bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow};
  endfunction

  // Reference queue model used by the hand-written sequences
  logic [7:0] mq[$];
  logic [7:0] m_last;
  bit         m_ovf, m_udf;

  function automatic logic [7:0] m_dout();
`ifdef FIFO_FWFT_EN
    return (mq.size() > 0) ? mq[0] : 8'h00;
`else
    return m_last;
`endif
  endfunction

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(bus.count), 32'(n));
    chk({tag, ".flags"}, 32'(dut_flags()),
        32'({n == D, n == 0, n >= AF, n <= AE, m_ovf, m_udf}));
    chk({tag, ".dout"}, 32'(bus.data_out), 32'(m_dout()));
  endtask

  task automatic step(input string tag, input logic c, input logic p, input logic q,
                      input logic [7:0] d);
    bit pop_ok, push_ok;
    FIFO_clr_n   = c;
    bus.push     = p;
    bus.pop      = q;
    bus.data_in  = d;
    @(posedge clk);
    if (!c) begin
      mq.delete();
      m_last = 8'h00;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      pop_ok  = q && (mq.size() > 0);
      push_ok = p && ((mq.size() < D) || pop_ok);
      if (pop_ok) m_last = mq.pop_front();
      if (push_ok) mq.push_back(d);
      if (p && !push_ok) m_ovf = 1'b1;
      if (q && !pop_ok)  m_udf = 1'b1;
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 6'b010100, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'hA2, 1, 6'b000100, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'hA8, 2, 6'b000100, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h1C, 3, 6'b000000, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h8B, 4, 6'b000000, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 3, 6'b000000, 8'hA2};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 2, 6'b000100, 8'hA8};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1, 6'b000100, 8'h1C};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 6'b010100, 8'h8B};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h55, 1, 6'b000101, 8'h8B};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 6'b010101, 8'h55};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 6'b010101, 8'h55};

    FIFO_reset  = 1'b1;
    FIFO_clr_n  = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = 8'h00;
    #12;
    chk("reset.count", 32'(bus.count), 32'd0);
    chk("reset.flags", 32'(dut_flags()), 32'b010100);
    chk("reset.dout", 32'(bus.data_out), 32'h00);
    FIFO_reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      FIFO_clr_n  = tbl[i].clr_n;
      bus.push    = tbl[i].push;
      bus.pop     = tbl[i].pop;
      bus.data_in = tbl[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.count", i), 32'(bus.count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.flags", i), 32'(dut_flags()), 32'(tbl[i].flags));
`ifndef FIFO_FWFT_EN
      chk($sformatf("vec%0d.dout", i), 32'(bus.data_out), 32'(tbl[i].dout));
`endif
    end

    // Fill to full, overflow, simultaneous push/pop at full, drain, underflow
    step("fill.clr", 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < D; i++) step($sformatf("fill%0d", i), 1'b1, 1'b1, 1'b0, 8'(i));
    step("fill.ovf", 1'b1, 1'b1, 1'b0, 8'h99);
    step("full.pushpop", 1'b1, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < D; i++) step($sformatf("drain%0d", i), 1'b1, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
    chk("drain.last", 32'(bus.data_out), 32'hFF);
`endif
    step("drain.udf", 1'b1, 1'b0, 1'b1, 8'h00);

    // Pointer wrap, then clear takes priority over a same-cycle push
    step("wrap.clr", 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step($sformatf("wrap.pre%0d", i), 1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 20; i++) step($sformatf("wrap%0d", i), 1'b1, 1'b1, 1'b1, 8'(8'h20 + i));
    step("clr.push", 1'b0, 1'b1, 1'b0, 8'h77);
    step("clr.after", 1'b1, 1'b0, 1'b1, 8'h00);

    // Asynchronous reset in the middle of a burst
    step("rst.clr", 1'b0, 1'b0, 1'b0, 8'h00);
    step("rst.p0", 1'b1, 1'b1, 1'b0, 8'hC1);
    step("rst.p1", 1'b1, 1'b1, 1'b0, 8'hC2);
    step("rst.p2", 1'b1, 1'b1, 1'b1, 8'hC3);
    bus.push    = 1'b1;
    bus.pop     = 1'b0;
    bus.data_in = 8'hAA;
    @(posedge clk);
    #2 FIFO_reset = 1'b1;
    #1;
    chk("arst.count", 32'(bus.count), 32'd0);
    chk("arst.flags", 32'(dut_flags()), 32'b010100);
    chk("arst.dout", 32'(bus.data_out), 32'h00);
    #2;
    bus.push   = 1'b0;
    FIFO_reset = 1'b0;
    mq.delete();
    m_last = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    step("post_rst.push", 1'b1, 1'b1, 1'b0, 8'h3C);
`ifdef FIFO_FWFT_EN
    chk("fwft.dout", 32'(bus.data_out), 32'h3C);
`endif
    step("post_rst.pop", 1'b1, 1'b0, 1'b1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
